mult_seq_ctrl: RTL
==================

# mult_seq_ctrl

Upstream sequencer for the team's 32x32 signed sequential shift/add multiplier. Accepts operand pairs over a valid/ready handshake, drives the multiplier's operand and level-sensitive start inputs, waits for its done strobe, captures the 64-bit product into a one-entry result register, and forces a start-low gap between operations so the multiplier re-arms. Zero operands bypass the multiplier. A watchdog converts a hung operation into a flagged result.

## Interface
- TAG_W, 4: width of the opaque tag carried from request to result.
- TIMEOUT, 48: maximum cycles in RUN before the watchdog fires; range 2..255.
- GAP_CYCLES, 2: cycles mul_start is held low after each multiplier operation; minimum 1.
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_a  in  32  multiplier operand, two's complement.
- in_b  in  32  multiplicand operand, two's complement.
- in_tag  in  TAG_W  request tag.
- mul_mlier  out  32  operand to the multiplier.
- mul_mcand  out  32  operand to the multiplier.
- mul_start  out  1  level start to the multiplier.
- mul_prodt  in  64  product from the multiplier.
- mul_valid  in  1  multiplier done strobe.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_prodt  out  64  signed 64-bit product.
- out_tag  out  TAG_W  tag of the result.
- out_timeout  out  1  result produced by the watchdog; out_prodt is 0.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, RUN, CAPT, GAP.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Because of this rule the result register is always free when a capture occurs.
- IDLE, accept, in_a == 0 or in_b == 0:
  - bypass; the result register loads prodt = 0, timeout = 0, tag = in_tag.
  - state stays IDLE and mul_start stays 0.
- IDLE, accept, both operands nonzero:
  - mul_mlier, mul_mcand and the tag register load from the request.
  - the watchdog counter clears to 0 and state goes to RUN.
- RUN:
  - mul_start = 1 and the counter increments each cycle.
  - mul_valid = 1 moves to CAPT.
  - if mul_valid = 1 and the counter reaches TIMEOUT-1 in the same cycle, mul_valid wins.
  - otherwise the counter reaching TIMEOUT-1 moves to GAP and loads the result register with prodt = 0, timeout = 1.
- CAPT:
  - mul_start = 1.
  - the result register loads mul_prodt, timeout = 0, and the stored tag.
  - next state is GAP.
- GAP:
  - mul_start = 0 for exactly GAP_CYCLES cycles, counted by a reused counter.
  - then IDLE.
- mul_mlier and mul_mcand stay stable from accept through the end of GAP. They hold their last value in IDLE.
- Result register: out_valid sets on load and clears on out_valid && out_ready. A load and a drain never coincide, because in_ready gates accepts.
- The block performs no arithmetic on the product; sign handling belongs to the multiplier.

## Timing
- Reset values: in_ready = 1, mul_start = 0, mul_mlier = mul_mcand = 0, out_valid = 0, out_prodt = 0, out_tag = 0, out_timeout = 0, busy = 0. State is IDLE and the counter is 0.
- Reset asserted mid-operation aborts it:
  - the pending result is lost.
  - mul_start is 0 in the cycle after the reset edge.
- All outputs are registered except in_ready, which is combinational from state, out_valid and out_ready.
- Multiplier path, accept at edge T:
  - mul_start goes high from T+1.
  - mul_valid is first seen at edge T+k; CAPT occupies cycle T+k+1.
  - out_valid is 1 from T+k+2.
  - mul_start is low from T+k+2 for GAP_CYCLES cycles.
  - in_ready can rise at T+k+2+GAP_CYCLES.
- Bypass path: accept at T gives out_valid from T+1. Back-to-back accepts at one per cycle are possible while out_ready = 1.
- Watchdog path: accept at T gives out_valid with out_timeout = 1 from T+TIMEOUT+1.
- mul_valid is ignored outside RUN.

## Test plan
- in_a = 3, in_b = 5, tag = 2, multiplier attached -> one mul_start high window, out_prodt = 15, out_tag = 2, out_timeout = 0; then mul_start low for 2 cycles before in_ready returns.
- in_a = -2 (0xFFFFFFFE), in_b = 7 -> out_prodt = 0xFFFFFFFFFFFFFFF2; then in_a = 0x80000000, in_b = 0x80000000 -> out_prodt = 0x4000000000000000.
- Four requests with in_a = 0 and out_ready held 1 -> four results with prodt 0 on consecutive cycles; mul_start never rises.
- Multiplier model that never raises mul_valid, TIMEOUT = 48 -> out_timeout = 1 and out_prodt = 0 at T+49; next request then completes normally.
- out_ready held 0 after a result -> in_ready = 0 and out_* stable; raising out_ready for 1 cycle allows the next accept in that same cycle.
- reset pulsed during RUN -> mul_start = 0, out_valid = 0 next cycle; a fresh 6 x 7 request then yields 42.

Source files
------------

// File: rtl/mult_seq_ctrl_if.sv
// Request, multiplier and result signal bundle for mult_seq_ctrl.
// master = request source / multiplier / result sink, slave = the sequencer.
interface mult_seq_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      mul_mlier;
  logic [31:0]      mul_mcand;
  logic             mul_start;
  logic [63:0]      mul_prodt;
  logic             mul_valid;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_prodt;
  logic [TAG_W-1:0] out_tag;
  logic             out_timeout;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_tag, mul_prodt, mul_valid, out_ready,
    input  in_ready, mul_mlier, mul_mcand, mul_start, out_valid, out_prodt,
           out_tag, out_timeout, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, mul_prodt, mul_valid, out_ready,
    output in_ready, mul_mlier, mul_mcand, mul_start, out_valid, out_prodt,
           out_tag, out_timeout, busy
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for a 32x32 signed shift/add multiplier: level start, done capture,
// re-arm gap, zero-operand bypass and watchdog; one-entry result register.
module mult_seq_ctrl #(
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 48,
  parameter int GAP_CYCLES = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  mult_seq_ctrl_if.slave io
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPT, S_GAP} state_t;

  localparam logic [7:0] RUN_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [31:0]      mlier_q, mlier_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             res_vld_q, res_vld_d;
  logic [63:0]      res_prodt_q, res_prodt_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_to_q, res_to_d;
  logic             in_ready;
  logic             accept;

  // Accepting only when the result slot is free (or draining) means every
  // later capture lands in an empty register.
  assign in_ready = (state_q == S_IDLE) && (!res_vld_q || io.out_ready);
  assign accept   = io.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mlier_d     = mlier_q;
    mcand_d     = mcand_q;
    tag_d       = tag_q;
    res_vld_d   = res_vld_q;
    res_prodt_d = res_prodt_q;
    res_tag_d   = res_tag_q;
    res_to_d    = res_to_q;

    if (res_vld_q && io.out_ready) begin
      res_vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (io.in_a == 32'd0 || io.in_b == 32'd0) begin
            res_vld_d   = 1'b1;
            res_prodt_d = 64'd0;
            res_tag_d   = io.in_tag;
            res_to_d    = 1'b0;
          end else begin
            mlier_d = io.in_a;
            mcand_d = io.in_b;
            tag_d   = io.in_tag;
            cnt_d   = 8'd0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 8'd1;
        // Done strobe wins over a watchdog expiry in the same cycle.
        if (io.mul_valid) begin
          state_d = S_CAPT;
        end else if (cnt_q == RUN_LAST) begin
          res_vld_d   = 1'b1;
          res_prodt_d = 64'd0;
          res_tag_d   = tag_q;
          res_to_d    = 1'b1;
          cnt_d       = 8'd0;
          state_d     = S_GAP;
        end
      end
      S_CAPT: begin
        res_vld_d   = 1'b1;
        res_prodt_d = io.mul_prodt;
        res_tag_d   = tag_q;
        res_to_d    = 1'b0;
        cnt_d       = 8'd0;
        state_d     = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase

    start_d = (state_d == S_RUN) || (state_d == S_CAPT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      mlier_q     <= 32'd0;
      mcand_q     <= 32'd0;
      tag_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      res_vld_q   <= 1'b0;
      res_prodt_q <= 64'd0;
      res_tag_q   <= '0;
      res_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mlier_q     <= mlier_d;
      mcand_q     <= mcand_d;
      tag_q       <= tag_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      res_vld_q   <= res_vld_d;
      res_prodt_q <= res_prodt_d;
      res_tag_q   <= res_tag_d;
      res_to_q    <= res_to_d;
    end
  end

  assign io.in_ready    = in_ready;
  assign io.mul_mlier   = mlier_q;
  assign io.mul_mcand   = mcand_q;
  assign io.mul_start   = start_q;
  assign io.out_valid   = res_vld_q;
  assign io.out_prodt   = res_prodt_q;
  assign io.out_tag     = res_tag_q;
  assign io.out_timeout = res_to_q;
  assign io.busy        = busy_q;

endmodule
